// File: rtl/eth_tx_frame_launcher.sv
// eth_tx_frame_launcher
// Reads complete frames from the FWFT side of the TX FIFO, prefixes the
// preamble and SFD, drives a GMII-style byte interface and then holds the
// line idle for the inter-frame gap. pct_txed pulses once for every frame
// that has been fully removed from the FIFO.
module eth_tx_frame_launcher #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned MAX_BYTES    = 1518
) (
  input  logic       eth_tx_clk,
  input  logic       rst,
  input  logic [1:0] buffer_ready,
  input  logic       fifo_empty,
  input  logic [8:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic       pct_txed,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_DRAIN,
    S_IFG
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] ifg_cnt_q;
  logic [10:0]      byte_cnt_q;
  logic [7:0]       txd_q;
  logic             tx_en_q;
  logic             tx_er_q;
  logic             pct_q;

  logic             pop_state;
  logic             word_last;
  logic             oversize;

  // The SFD cycle already pops the first data byte so that it lands on the
  // wire directly after 0xD5; DRAIN pops to discard the rest of a bad frame.
  assign pop_state = (state_q == S_SFD) || (state_q == S_DATA) || (state_q == S_DRAIN);
  // NOTE: the pop strobe is combinational so the FIFO advances in the same
  // cycle the word is consumed; it must never assert on an empty FIFO.
  assign fifo_rd_en = !rst && !fifo_empty && pop_state;
  assign word_last  = fifo_rd_data[8];
  // Byte number MAX_BYTES+1 without an end marker means the frame is too long.
  assign oversize   = (byte_cnt_q >= 11'(MAX_BYTES)) && !word_last;

  assign busy       = (state_q != S_IDLE);
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign pct_txed   = pct_q;

  // Frame sequencer with registered GMII outputs and frame-done pulse.
  always_ff @(posedge eth_tx_clk) begin
    // NOTE: reset is synchronous and covers every register; there is no
    // storage array here, so nothing is left uninitialised after reset.
    if (rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      ifg_cnt_q  <= '0;
      byte_cnt_q <= '0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      pct_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // state of the previous cycle regardless of statement order.
      pct_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q   <= '0;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (buffer_ready != 2'd0 && !fifo_empty) begin
            state_q    <= S_PREAMBLE;
            pre_cnt_q  <= '0;
            byte_cnt_q <= '0;
            txd_q      <= PRE_BYTE;
            tx_en_q    <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          tx_en_q <= 1'b1;
          tx_er_q <= 1'b0;
          if (pre_cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            txd_q   <= SFD_BYTE;
            state_q <= S_SFD;
          end else begin
            txd_q     <= PRE_BYTE;
            pre_cnt_q <= pre_cnt_q + CNT_W'(1);
          end
        end

        S_SFD, S_DATA: begin
          tx_en_q <= 1'b1;
          if (fifo_empty) begin
            // Underrun: flag the frame as corrupt and discard its remainder.
            txd_q   <= '0;
            tx_er_q <= 1'b1;
            state_q <= S_DRAIN;
          end else if (oversize) begin
            // Too long: the popped byte is dropped and an error is signalled.
            txd_q   <= '0;
            tx_er_q <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            txd_q   <= fifo_rd_data[7:0];
            tx_er_q <= 1'b0;
            if (byte_cnt_q != '1) begin
              byte_cnt_q <= byte_cnt_q + 11'd1;
            end
            if (word_last) begin
              pct_q     <= 1'b1;
              ifg_cnt_q <= '0;
              state_q   <= S_IFG;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DRAIN: begin
          txd_q   <= '0;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (!fifo_empty && word_last) begin
            pct_q     <= 1'b1;
            ifg_cnt_q <= '0;
            state_q   <= S_IFG;
          end
        end

        S_IFG: begin
          txd_q   <= '0;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (ifg_cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
            state_q <= S_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_launcher.sv
// Directed bench for eth_tx_frame_launcher: a default instance and a second
// instance with MAX_BYTES=8 share one FIFO model; sel_os picks which one is
// fed and observed.
module tb_eth_tx_frame_launcher;

  localparam int PRE = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] buffer_ready;
  logic       fifo_empty;
  logic [8:0] fifo_rd_data;
  logic       sel_os;
  bit         stall;

  logic [1:0] br_m, br_os;
  logic       fe_m, fe_os;
  logic       rd_m, pct_m, en_m, er_m, busy_m;
  logic       rd_os, pct_os, en_os, er_os, busy_os;
  logic [7:0] txd_m, txd_os;

  logic       obs_rd, obs_pct, obs_en, obs_er, obs_busy;
  logic [7:0] obs_txd;
  logic [10:0] obs_vec;

  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt, pct_cnt, en_cnt;

  logic [8:0] fq[$];
  logic [7:0] exp_bytes[$];

  always #5 clk = ~clk;

  assign br_m  = sel_os ? 2'd0 : buffer_ready;
  assign br_os = sel_os ? buffer_ready : 2'd0;
  assign fe_m  = sel_os ? 1'b1 : fifo_empty;
  assign fe_os = sel_os ? fifo_empty : 1'b1;

  assign obs_rd   = sel_os ? rd_os   : rd_m;
  assign obs_pct  = sel_os ? pct_os  : pct_m;
  assign obs_en   = sel_os ? en_os   : en_m;
  assign obs_er   = sel_os ? er_os   : er_m;
  assign obs_busy = sel_os ? busy_os : busy_m;
  assign obs_txd  = sel_os ? txd_os  : txd_m;
  assign obs_vec  = {obs_en, obs_er, obs_pct, obs_txd};

  eth_tx_frame_launcher dut (
    .eth_tx_clk   (clk),
    .rst          (rst),
    .buffer_ready (br_m),
    .fifo_empty   (fe_m),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (rd_m),
    .pct_txed     (pct_m),
    .gmii_txd     (txd_m),
    .gmii_tx_en   (en_m),
    .gmii_tx_er   (er_m),
    .busy         (busy_m)
  );

  eth_tx_frame_launcher #(.MAX_BYTES(8)) dut_os (
    .eth_tx_clk   (clk),
    .rst          (rst),
    .buffer_ready (br_os),
    .fifo_empty   (fe_os),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (rd_os),
    .pct_txed     (pct_os),
    .gmii_txd     (txd_os),
    .gmii_tx_en   (en_os),
    .gmii_tx_er   (er_os),
    .busy         (busy_os)
  );

  function automatic logic [10:0] v(input bit en, input bit er, input bit pct, input logic [7:0] d);
    return {en, er, pct, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty   = stall || (fq.size() == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : 9'h000;
  endtask

  task automatic add(input logic [7:0] b, input bit last);
    fq.push_back({last, b});
    exp_bytes.push_back(b);
    drive_fifo();
  endtask

  // One clock: the pop decision is what the DUT sees at the edge; outputs
  // are sampled 1 ns after the edge.
  task automatic tick();
    logic pop;
    pop = obs_rd;
    @(posedge clk);
    #1;
    if (pop) begin
      rd_cnt++;
      if (fq.size() != 0) void'(fq.pop_front());
    end
    if (obs_pct) pct_cnt++;
    if (obs_en)  en_cnt++;
    drive_fifo();
  endtask

  // Entered with cycle 1 (first preamble byte) already on the wire; checks
  // preamble, SFD and the first n bytes of exp_bytes.
  task automatic expect_frame(input int n, input bit pct_end, input string tag);
    logic [7:0] d;
    int last_i;
    last_i = PRE + 1 + n;
    for (int i = 1; i <= last_i; i++) begin
      if (i > 1) tick();
      if (i <= PRE)          d = 8'h55;
      else if (i == PRE + 1) d = 8'hD5;
      else                   d = exp_bytes[i - PRE - 2];
      chk($sformatf("%s_c%0d", tag, i), 32'(obs_vec),
          32'(v(1'b1, 1'b0, (i == last_i) && pct_end, d)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    rst = 1'b1; buffer_ready = 2'd0; stall = 1'b0; sel_os = 1'b0;
    rd_cnt = 0; pct_cnt = 0; en_cnt = 0;
    drive_fifo();

    // Reset state
    repeat (3) tick();
    chk("rst_outputs", 32'(obs_vec), 32'(0));
    chk("rst_busy", 32'(obs_busy), 32'(0));
    chk("rst_rd_en", 32'(obs_rd), 32'(0));
    rst = 1'b0;

    // Reset in the middle of the preamble aborts the frame
    add(8'h11, 1'b0); add(8'h22, 1'b0); add(8'h33, 1'b0); add(8'h44, 1'b1);
    buffer_ready = 2'd1;
    tick();
    chk("pre_start", 32'(obs_vec), 32'(v(1, 0, 0, 8'h55)));
    tick(); tick();
    rst = 1'b1; rd_cnt = 0; pct_cnt = 0;
    tick();
    chk("rst_abort_en", 32'(obs_vec), 32'(0));
    tick(); tick();
    rst = 1'b0; buffer_ready = 2'd0;
    repeat (5) tick();
    chk("rst_abort_rd", 32'(rd_cnt), 32'(0));
    chk("rst_abort_pct", 32'(pct_cnt), 32'(0));
    chk("rst_abort_busy", 32'(obs_busy), 32'(0));
    chk("rst_abort_fifo", 32'(fq.size()), 32'(4));

    // 4-byte frame, then 12 idle cycles
    buffer_ready = 2'd1; rd_cnt = 0;
    tick();
    expect_frame(4, 1'b1, "f4");
    buffer_ready = 2'd0; en_cnt = 0; pct_cnt = 0;
    repeat (11) tick();
    chk("f4_ifg_busy", 32'(obs_busy), 32'(1));
    tick();
    chk("f4_idle_busy", 32'(obs_busy), 32'(0));
    chk("f4_ifg_en", 32'(en_cnt), 32'(0));
    chk("f4_ifg_pct", 32'(pct_cnt), 32'(0));
    chk("f4_pops", 32'(rd_cnt), 32'(4));
    exp_bytes.delete();

    // Back-to-back frames: second preamble IFG+1 cycles after last byte
    add(8'hA1, 1'b0); add(8'hB2, 1'b1); add(8'hC3, 1'b0); add(8'hD4, 1'b1);
    buffer_ready = 2'd2;
    tick();
    expect_frame(2, 1'b1, "b2b_f1");
    buffer_ready = 2'd1;
    void'(exp_bytes.pop_front()); void'(exp_bytes.pop_front());
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!obs_en && gap < 40);
    chk("b2b_gap", 32'(gap), 32'(13));
    expect_frame(2, 1'b1, "b2b_f2");
    buffer_ready = 2'd0;
    exp_bytes.delete();
    repeat (13) tick();
    chk("b2b_idle", 32'(obs_busy), 32'(0));

    // Underrun after byte 2 of 5
    add(8'h01, 1'b0); add(8'h02, 1'b0); add(8'h03, 1'b0); add(8'h04, 1'b0); add(8'h05, 1'b1);
    buffer_ready = 2'd1; rd_cnt = 0;
    tick();
    expect_frame(2, 1'b0, "ur");
    stall = 1'b1; drive_fifo();
    tick();
    chk("ur_err", 32'(obs_vec), 32'(v(1, 1, 0, 8'h00)));
    tick();
    chk("ur_drain_c12", 32'(obs_vec), 32'(0));
    tick();
    stall = 1'b0; drive_fifo();
    chk("ur_drain_c13", 32'(obs_vec), 32'(0));
    tick();
    chk("ur_drain_c14", 32'(obs_vec), 32'(0));
    tick();
    chk("ur_drain_c15", 32'(obs_vec), 32'(0));
    tick();
    chk("ur_pct", 32'(obs_vec), 32'(v(0, 0, 1, 8'h00)));
    chk("ur_pops", 32'(rd_cnt), 32'(5));
    buffer_ready = 2'd0;
    tick();
    chk("ur_pct_once", 32'(obs_vec), 32'(0));
    repeat (10) tick();
    chk("ur_ifg_busy", 32'(obs_busy), 32'(1));
    tick();
    chk("ur_idle", 32'(obs_busy), 32'(0));
    exp_bytes.delete();

    // Oversize: 10-byte frame into the MAX_BYTES=8 instance
    sel_os = 1'b1; drive_fifo();
    for (int i = 0; i < 10; i++) add(8'hA0 + 8'(i), i == 9);
    buffer_ready = 2'd1; rd_cnt = 0;
    tick();
    expect_frame(8, 1'b0, "os");
    tick();
    chk("os_err", 32'(obs_vec), 32'(v(1, 1, 0, 8'h00)));
    tick();
    chk("os_pct", 32'(obs_vec), 32'(v(0, 0, 1, 8'h00)));
    buffer_ready = 2'd0;
    tick();
    chk("os_pct_once", 32'(obs_vec), 32'(0));
    chk("os_pops", 32'(rd_cnt), 32'(10));
    chk("os_fifo_empty", 32'(fq.size()), 32'(0));
    repeat (11) tick();
    chk("os_idle", 32'(obs_busy), 32'(0));
    sel_os = 1'b0; drive_fifo();
    exp_bytes.delete();

    // No start with buffer_ready=0, nor with an empty FIFO
    add(8'h5A, 1'b0); add(8'h6B, 1'b0); add(8'h7C, 1'b1);
    buffer_ready = 2'd0; rd_cnt = 0; en_cnt = 0;
    repeat (50) tick();
    chk("nordy_rd", 32'(rd_cnt), 32'(0));
    chk("nordy_en", 32'(en_cnt), 32'(0));
    chk("nordy_busy", 32'(obs_busy), 32'(0));
    stall = 1'b1; buffer_ready = 2'd1; drive_fifo();
    repeat (10) tick();
    chk("empty_wait_en", 32'(en_cnt), 32'(0));
    chk("empty_wait_rd", 32'(rd_cnt), 32'(0));
    stall = 1'b0; drive_fifo();
    tick();
    expect_frame(3, 1'b1, "late");
    buffer_ready = 2'd0;
    repeat (13) tick();
    chk("late_idle", 32'(obs_busy), 32'(0));
    chk("late_pops", 32'(rd_cnt), 32'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
